// File: rtl/zapper_shot_ctrl_if.sv
// CPU-side bus of the zapper shot controller: address decode, read/write strobes and status readback.
interface zapper_shot_ctrl_if #(
  parameter int WIDTH         = 16,
  parameter int RAM_ADDR_BITS = 16
);
  logic [RAM_ADDR_BITS-1:0] adr;
  logic                     memread;
  logic                     memwrite;
  logic [WIDTH-1:0]         writedata;
  logic [WIDTH-1:0]         dataOut;
  logic                     sel;

  modport master (
    output adr, memread, memwrite, writedata,
    input  dataOut, sel
  );

  modport slave (
    input  adr, memread, memwrite, writedata,
    output dataOut, sel
  );
endinterface

// File: rtl/zapper_shot_ctrl.sv
// Light-gun shot sequencer: debounced trigger, black/target frame phases, photodiode
// sampling and a CPU-visible status/control word.
module zapper_shot_ctrl #(
  parameter int                     WIDTH         = 16,
  parameter int                     RAM_ADDR_BITS = 16,
  parameter logic [RAM_ADDR_BITS-1:0] ZAP_ADDR    = 16'hBFFC,
  parameter int                     SYNC_STAGES   = 2,
  parameter int                     DEBOUNCE_CYC  = 50000,
  parameter int                     BLACK_CYC     = 833333,
  parameter int                     TARGET_CYC    = 833333
) (
  input  logic                clk,
  input  logic                reset,
  zapper_shot_ctrl_if.slave   bus,
  input  logic                trigger_in,
  input  logic                detect_in,
  output logic                vga_black,
  output logic                vga_target,
  output logic                shot_busy
);

  localparam int PH_MAX = (BLACK_CYC > TARGET_CYC) ? BLACK_CYC : TARGET_CYC;
  localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam int DB_W   = $clog2(DEBOUNCE_CYC + 1);

  typedef enum logic [2:0] {IDLE, BLACK, TARGET, DONE, HOLDOFF} state_t;

  state_t                  state_q, state_d;
  logic [PH_W-1:0]         phase_q, phase_d;
  logic                    amb_q, amb_d, tgt_q, tgt_d;
  logic [SYNC_STAGES-1:0]  trig_sync_q, det_sync_q;
  logic [DB_W-1:0]         db_cnt_q;
  logic                    trig_db_q, trig_db_prev_q;
  logic                    valid_q, valid_d, hit_q, hit_d, fault_q, fault_d, arm_q, arm_d;
  logic [7:0]              count_q, count_d;
  logic                    trig_s, det_s, trig_rise, done, rd, wr;
  logic [15:0]             status;
  logic                    unused_wd;

  assign trig_s    = trig_sync_q[SYNC_STAGES-1];
  assign det_s     = det_sync_q[SYNC_STAGES-1];
  assign trig_rise = trig_db_q & ~trig_db_prev_q;
  assign unused_wd = ^bus.writedata;

  // NOTE: every flop uses <= so all registers update from pre-edge values, independent of block order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      trig_sync_q    <= '0;
      det_sync_q     <= '0;
      db_cnt_q       <= '0;
      trig_db_q      <= 1'b0;
      trig_db_prev_q <= 1'b0;
    end else begin
      trig_sync_q    <= {trig_sync_q[SYNC_STAGES-2:0], trigger_in};
      det_sync_q     <= {det_sync_q[SYNC_STAGES-2:0], detect_in};
      trig_db_prev_q <= trig_db_q;
      if (trig_s == trig_db_q) begin
        db_cnt_q <= '0;
      end else if (db_cnt_q == DB_W'(DEBOUNCE_CYC - 1)) begin
        trig_db_q <= trig_s;
        db_cnt_q  <= '0;
      end else begin
        db_cnt_q <= db_cnt_q + 1'b1;
      end
    end
  end

  // NOTE: defaults first so every path assigns every signal and no latch is inferred.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    amb_d   = amb_q;
    tgt_d   = tgt_q;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (trig_rise && arm_q) begin
          state_d = BLACK;
          phase_d = '0;
        end
      end
      BLACK: begin
        if (det_s) amb_d = 1'b1;
        if (phase_q == PH_W'(BLACK_CYC - 1)) begin
          state_d = TARGET;
          phase_d = '0;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      TARGET: begin
        if (det_s) tgt_d = 1'b1;
        if (phase_q == PH_W'(TARGET_CYC - 1)) begin
          state_d = DONE;
          phase_d = '0;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      DONE: begin
        done    = 1'b1;
        amb_d   = 1'b0;
        tgt_d   = 1'b0;
        state_d = HOLDOFF;
      end
      HOLDOFF: begin
        // A held trigger keeps us here, so it can never fire a second shot.
        if (!trig_db_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rd = bus.memread & bus.sel;
  assign wr = bus.memwrite & bus.sel;

  // The DONE update is applied last so a finishing shot wins over a coincident read or write.
  always_comb begin
    valid_d = valid_q;
    hit_d   = hit_q;
    fault_d = fault_q;
    arm_d   = arm_q;
    count_d = count_q;
    if (rd) valid_d = 1'b0;
    if (wr) begin
      arm_d = bus.writedata[0];
      if (bus.writedata[14]) begin
        valid_d = 1'b0;
        hit_d   = 1'b0;
        fault_d = 1'b0;
      end
      if (bus.writedata[15]) count_d = 8'd0;
    end
    if (done) begin
      hit_d   = tgt_q & ~amb_q;
      fault_d = amb_q;
      valid_d = 1'b1;
      count_d = count_d + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      phase_q    <= '0;
      amb_q      <= 1'b0;
      tgt_q      <= 1'b0;
      valid_q    <= 1'b0;
      hit_q      <= 1'b0;
      fault_q    <= 1'b0;
      arm_q      <= 1'b1;
      count_q    <= 8'd0;
      vga_black  <= 1'b0;
      vga_target <= 1'b0;
      shot_busy  <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      amb_q      <= amb_d;
      tgt_q      <= tgt_d;
      valid_q    <= valid_d;
      hit_q      <= hit_d;
      fault_q    <= fault_d;
      arm_q      <= arm_d;
      count_q    <= count_d;
      vga_black  <= (state_d == BLACK);
      vga_target <= (state_d == TARGET);
      shot_busy  <= (state_d == BLACK) || (state_d == TARGET) || (state_d == DONE);
    end
  end

  assign status      = {count_q, 3'b000, arm_q, fault_q, shot_busy, hit_q, valid_q};
  assign bus.sel     = (bus.adr == ZAP_ADDR);
  assign bus.dataOut = bus.sel ? WIDTH'(status) : '0;

endmodule
